// File: rtl/fwd_pkg.sv
// Shared constants for the ID-stage forwarding / hazard unit.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int REG_AW_DEF = 4;

endpackage : fwd_pkg

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: resolves one ID operand against the EX and MEM writers.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              fwd_en_i,
  input  logic              src_valid_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              ex_wb_en_i,
  input  logic              ex_mem_r_en_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic              mem_wb_en_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  output logic [1:0]        next_sel_o,
  output logic              stall_req_o,
  output logic              hit_o
);

  logic m_ex;
  logic m_mem;

  assign m_ex  = src_valid_i && ex_wb_en_i  && (src_i == ex_dest_i);
  assign m_mem = src_valid_i && mem_wb_en_i && (src_i == mem_dest_i);

  // EX producer reaches MEM next cycle, so it wins over the older MEM producer.
  always_comb begin
    next_sel_o  = FWD_RF;
    stall_req_o = 1'b0;
    if (fwd_en_i) begin
      if (m_ex)       next_sel_o = FWD_MEM;
      else if (m_mem) next_sel_o = FWD_WB;
      stall_req_o = m_ex && ex_mem_r_en_i;
    end else begin
      stall_req_o = m_ex || m_mem;
    end
  end

  assign hit_o = (next_sel_o != FWD_RF);

endmodule : fwd_src_cmp

// File: rtl/fwd_hazard_unit.sv
// ID-stage hazard resolution: registered EX forwarding selects, load-use stall
// and saturating stall/forward event counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      clr_cnt,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_r_en,
  input  logic [REG_AW-1:0]         ex_dest,
  input  logic                      mem_wb_en,
  input  logic [REG_AW-1:0]         mem_dest,
  output logic                      hazard_stall,
  output logic [NUM_SRC*2-1:0]      ex_sel,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
);

  logic [NUM_SRC*2-1:0] next_sel;
  logic [NUM_SRC-1:0]   stall_req;
  logic [NUM_SRC-1:0]   hit;

  logic [NUM_SRC*2-1:0] ex_sel_q, ex_sel_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     fwd_cnt_q, fwd_cnt_d;
  logic                 load_normal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic              inc);
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + 1'b1;
    return cnt;
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp (
      .fwd_en_i      (fwd_en),
      .src_valid_i   (id_src_valid[i]),
      .src_i         (id_src[i*REG_AW +: REG_AW]),
      .ex_wb_en_i    (ex_wb_en),
      .ex_mem_r_en_i (ex_mem_r_en),
      .ex_dest_i     (ex_dest),
      .mem_wb_en_i   (mem_wb_en),
      .mem_dest_i    (mem_dest),
      .next_sel_o    (next_sel[2*i +: 2]),
      .stall_req_o   (stall_req[i]),
      .hit_o         (hit[i])
    );
  end

  assign hazard_stall = |stall_req;
  assign load_normal  = !flush && !freeze && !hazard_stall;

  // Flush beats freeze; a stall loads a bubble (all selects to register file).
  always_comb begin
    ex_sel_d = ex_sel_q;
    if (flush)             ex_sel_d = '0;
    else if (freeze)       ex_sel_d = ex_sel_q;
    else if (hazard_stall) ex_sel_d = '0;
    else                   ex_sel_d = next_sel;
  end

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, hazard_stall && !freeze && !flush);
    fwd_cnt_d   = sat_inc(fwd_cnt_q, load_normal && (|hit));
    if (clr_cnt) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_sel_q    <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      ex_sel_q    <= ex_sel_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign ex_sel    = ex_sel_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: driver pushes expected state, monitor compares.
module tb_fwd_hazard_unit;

  localparam int AW = 4;
  localparam int NS = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, fwd_en, freeze, flush, clr_cnt;
  logic [NS-1:0]   id_src_valid;
  logic [NS*AW-1:0] id_src;
  logic            ex_wb_en, ex_mem_r_en, mem_wb_en;
  logic [AW-1:0]   ex_dest, mem_dest;
  logic            hazard_stall;
  logic [NS*2-1:0] ex_sel;
  logic [CW-1:0]   stall_cnt, fwd_cnt;

  typedef struct packed {
    logic [NS*2-1:0] sel;
    logic [CW-1:0]   sc;
    logic [CW-1:0]   fc;
  } exp_t;

  exp_t q[$];
  logic [NS*2-1:0] m_sel = '0;
  int              m_sc = 0, m_fc = 0;
  int              n_chk = 0, n_fail = 0;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .freeze(freeze), .flush(flush),
    .clr_cnt(clr_cnt), .id_src_valid(id_src_valid), .id_src(id_src),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard_stall(hazard_stall),
    .ex_sel(ex_sel), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; fwd_en = 1; freeze = 0; flush = 0; clr_cnt = 0;
    id_src_valid = '0; id_src = '0;
    ex_wb_en = 0; ex_mem_r_en = 0; ex_dest = '0;
    mem_wb_en = 0; mem_dest = '0;
  endtask

  // Reference: evaluate the hazard rules on current inputs, predict next state,
  // then advance to the following negedge.
  task automatic cycle();
    bit       mex, mmem, any_ld, any_raw, any_fwd, stall;
    logic [NS*2-1:0] nsel;
    logic [AW-1:0] s;
    int       top;
    exp_t     e;
    #1;
    any_ld = 0; any_raw = 0; any_fwd = 0; nsel = '0;
    top = (1 << CW) - 1;
    for (int i = 0; i < NS; i++) begin
      s    = id_src[i*AW +: AW];
      mex  = id_src_valid[i] && ex_wb_en  && (s == ex_dest);
      mmem = id_src_valid[i] && mem_wb_en && (s == mem_dest);
      if (mex && ex_mem_r_en) any_ld = 1;
      if (mex || mmem) any_raw = 1;
      if (fwd_en && mex)       nsel[2*i +: 2] = 2'b01;
      else if (fwd_en && mmem) nsel[2*i +: 2] = 2'b10;
      if (nsel[2*i +: 2] != 2'b00) any_fwd = 1;
    end
    stall = fwd_en ? any_ld : any_raw;
    chk("hazard_stall", 32'(hazard_stall), 32'(stall));
    if (rst || clr_cnt) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (stall && !freeze && !flush && m_sc < top) m_sc++;
      if (!flush && !freeze && !stall && any_fwd && m_fc < top) m_fc++;
    end
    if (rst || flush)  m_sel = '0;
    else if (freeze)   m_sel = m_sel;
    else if (stall)    m_sel = '0;
    else               m_sel = nsel;
    e.sel = m_sel; e.sc = CW'(m_sc); e.fc = CW'(m_fc);
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_sel", 32'(ex_sel), 32'(e.sel));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("fwd_cnt", 32'(fwd_cnt), 32'(e.fc));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); rst = 1;
    @(negedge clk);
    cycle(); cycle();
    chk("reset ex_sel", 32'(ex_sel), 0);
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    idle();

    // EX ALU result forward on source 0
    ex_wb_en = 1; ex_dest = 4'd3; id_src = {4'd9, 4'd9, 4'd3}; id_src_valid = 3'b001;
    cycle();
    chk("ex fwd sel0", 32'(ex_sel[1:0]), 32'b01);
    chk("ex fwd cnt", 32'(fwd_cnt), 1);

    // load-use on source 1, then MEM forward after the bubble
    idle(); ex_wb_en = 1; ex_mem_r_en = 1; ex_dest = 4'd5;
    id_src = {4'd9, 4'd5, 4'd9}; id_src_valid = 3'b010;
    cycle();
    chk("load-use bubble", 32'(ex_sel), 0);
    ex_wb_en = 0; ex_mem_r_en = 0; mem_wb_en = 1; mem_dest = 4'd5;
    cycle();
    chk("post-load sel1", 32'(ex_sel[3:2]), 32'b10);
    chk("load-use stall_cnt", 32'(stall_cnt), 1);

    // EX beats MEM for the same register
    idle(); ex_wb_en = 1; ex_dest = 4'd2; mem_wb_en = 1; mem_dest = 4'd2;
    id_src = {4'd9, 4'd9, 4'd2}; id_src_valid = 3'b001;
    cycle();
    chk("ex priority", 32'(ex_sel[1:0]), 32'b01);

    // stall-only mode
    idle(); fwd_en = 0; mem_wb_en = 1; mem_dest = 4'd7;
    id_src = {4'd7, 4'd9, 4'd9}; id_src_valid = 3'b100;
    #1 chk("nofwd stall", 32'(hazard_stall), 1);
    cycle();
    chk("nofwd sel", 32'(ex_sel), 0);
    id_src_valid = 3'b000;
    #1 chk("nofwd invalid", 32'(hazard_stall), 0);
    cycle();

    // freeze holds, flush during freeze clears
    idle(); ex_wb_en = 1; ex_dest = 4'd1; id_src = {4'd9, 4'd9, 4'd1}; id_src_valid = 3'b001;
    cycle();
    ex_dest = 4'd0; mem_wb_en = 1; mem_dest = 4'd1; freeze = 1;
    repeat (3) cycle();
    chk("freeze hold", 32'(ex_sel[1:0]), 32'b01);
    flush = 1;
    cycle();
    chk("flush in freeze", 32'(ex_sel), 0);

    // saturate stall counter, then clear together with a stall
    idle(); fwd_en = 0; mem_wb_en = 1; mem_dest = 4'd6;
    id_src = {4'd9, 4'd9, 4'd6}; id_src_valid = 3'b001;
    repeat (20) cycle();
    chk("stall sat", 32'(stall_cnt), 32'((1 << CW) - 1));
    clr_cnt = 1;
    cycle();
    chk("clr wins", 32'(stall_cnt), 0);

    // randomized traffic over a small register window to provoke hits
    idle();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      fwd_en       = ($urandom_range(0, 3) != 0);
      freeze       = ($urandom_range(0, 7) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      clr_cnt      = ($urandom_range(0, 29) == 0);
      id_src_valid = NS'($urandom);
      for (int i = 0; i < NS; i++) id_src[i*AW +: AW] = AW'($urandom_range(0, 3));
      ex_wb_en     = $urandom_range(0, 1) != 0;
      ex_mem_r_en  = $urandom_range(0, 2) == 0;
      ex_dest      = AW'($urandom_range(0, 3));
      mem_wb_en    = $urandom_range(0, 1) != 0;
      mem_dest     = AW'($urandom_range(0, 3));
      cycle();
    end

    idle();
    @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
